// File: rtl/alu_share_if.sv
// Requester-side bundle of alu_share_arbiter: request and response valid/ready handshakes.
// master = requester side, slave = arbiter side.
interface alu_share_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [4*NREQ-1:0]    req_op;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [31:0]          resp_data;
    logic [3:0]           resp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_data, resp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Optional MULDIV_STALL_EN: ops 4'b1110/4'b1111 hold EXEC for MULDIV_CYCLES cycles.
module alu_share_arbiter #(
    parameter int NREQ          = 2,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_if.slave       bus,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_out,
    input  logic [3:0]       alu_flags,
    output logic             busy
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MULDIV_CYCLES < 1) begin : g_param_check
        $error("alu_share_arbiter: NREQ must be 2..8 and MULDIV_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [31:0]     alu_a_q, alu_a_d;
    logic [31:0]     alu_b_q, alu_b_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic [3:0]      resp_flags_q, resp_flags_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [NREQ-1:0] req_ready;
    logic [PW-1:0]   pick;
    logic [3:0]      pick_op;
    logic            any_valid;
    logic            exec_last;

    // First valid requester strictly after the last-served pointer, wrapping.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
        logic [PW-1:0] sel;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(p) + k) % NREQ;
            if (!found && v[PW'(idx)]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    assign any_valid = |bus.req_valid;
    assign pick      = rr_pick(bus.req_valid, ptr_q);
    assign pick_op   = bus.req_op[{pick, 2'b00} +: 4];

`ifdef MULDIV_STALL_EN
    localparam int CW = $clog2(MULDIV_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && any_valid) begin
            cnt_d = (pick_op[3:1] == 3'b111) ? CW'(MULDIV_CYCLES - 1) : '0;
        end else if (state_q == EXEC && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign exec_last = (cnt_q == '0);
`else
    assign exec_last = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        resp_valid_d = resp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready = onehot(pick);
                    gnt_d     = pick;
                    alu_a_d   = bus.req_a[{pick, 5'b00000} +: 32];
                    alu_b_d   = bus.req_b[{pick, 5'b00000} +: 32];
                    alu_op_d  = pick_op;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    resp_data_d  = alu_out;
                    resp_flags_d = alu_flags;
                    resp_valid_d = onehot(gnt_q);
                    state_d      = RESP;
                end
            end
            RESP: begin
                // Only the granted requester's resp_ready matters.
                if (bus.resp_ready[gnt_q]) begin
                    resp_valid_d = '0;
                    ptr_d        = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= PW'(NREQ - 1);
            gnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_flags = resp_flags_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign busy           = (state_q != IDLE);
endmodule
